// File: rtl/cern_be_master.sv
// Single-outstanding initiator for the CERN-BE register bus: valid/ready request in, one-cycle strobe out, Done or timeout back.
// Optional timeout counter on err_cnt_o is built only when CERN_BE_MASTER_ERR_CNT_EN is defined.
module cern_be_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] VMEAddr,
  output logic [DATA_WIDTH-1:0] VMEWrData,
  input  logic [DATA_WIDTH-1:0] VMERdData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone,
  output logic [15:0]           err_cnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic                    rd_mem_reg, rd_mem_next;
  logic                    wr_mem_reg, wr_mem_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic                    rsp_err_reg, rsp_err_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                    done_match;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rd_mem_reg    <= 1'b0;
      wr_mem_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rd_mem_reg    <= rd_mem_next;
      wr_mem_reg    <= wr_mem_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  // cnt_reg is 0 in the strobe cycle, so Done is only honoured for cnt 1..TIMEOUT.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rd_mem_next    = 1'b0;
    wr_mem_next    = 1'b0;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    done_match     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          addr_next = req_addr_i;
          cnt_next  = '0;
          if (req_we_i) begin
            wdata_next  = req_wdata_i;
            wr_mem_next = 1'b1;
            state_next  = WR_WAIT;
          end else begin
            rd_mem_next = 1'b1;
            state_next  = RD_WAIT;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        done_match = (state_reg == RD_WAIT) ? VMERdDone : VMEWrDone;
        if (cnt_reg != '0 && done_match) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = (state_reg == RD_WAIT) ? VMERdData : '0;
          state_next     = IDLE;
        end else if (cnt_reg == TO_VAL) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready_o = (state_reg == IDLE);
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign rsp_rdata_o = rsp_rdata_reg;
  assign VMEAddr     = addr_reg;
  assign VMEWrData   = wdata_reg;
  assign VMERdMem    = rd_mem_reg;
  assign VMEWrMem    = wr_mem_reg;

`ifdef CERN_BE_MASTER_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  // Counts on the registered timeout response; saturating, cleared only by reset.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (rsp_valid_reg && rsp_err_reg && err_cnt_reg != 16'hFFFF) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_reg;
`else
  assign err_cnt_o = 16'd0;
`endif

endmodule
